// File: rtl/mul_div_unit.sv
// mul_div_unit: fixed-latency multiply/divide unit feeding the Hi/Lo registers.
// Results are computed at accept, held pending while busy, then committed together.
module mul_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        flush,
  input  logic [3:0]  mul_div_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // mfhi/mflo and unlisted codes fall through to "no state change"
  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b1000;

  logic [0:0]       r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [31:0]      r_pend_hi, w_pend_hi_nx;
  logic [31:0]      r_pend_lo, w_pend_lo_nx;
  logic             r_pend_wr, w_pend_wr_nx;
  logic             r_busy, w_busy_nx;
  logic [31:0]      r_hi, w_hi_nx;
  logic [31:0]      r_lo, w_lo_nx;

  logic        w_accept;
  logic [63:0] w_smul, w_umul;
  logic        w_sdiv, w_a_neg, w_b_neg;
  logic [31:0] w_a_mag, w_b_mag, w_q_mag, w_r_mag, w_quot, w_rem;

  assign w_accept = (r_state == S_IDLE) && start && !flush;

  // Low 64 bits of the sign-extended product equal the signed 64-bit product
  assign w_smul = {{32{A[31]}}, A} * {{32{B[31]}}, B};
  assign w_umul = {32'd0, A} * {32'd0, B};

  // Sign-magnitude division on one unsigned divider; 0x80000000/-1 falls out naturally.
  // A zero divisor is replaced by 1 only to keep the datapath defined; the result is discarded.
  assign w_sdiv  = (mul_div_op == OP_DIV);
  assign w_a_neg = w_sdiv && A[31];
  assign w_b_neg = w_sdiv && B[31];
  assign w_a_mag = w_a_neg ? (32'd0 - A) : A;
  assign w_b_mag = (B == 32'd0) ? 32'd1 : (w_b_neg ? (32'd0 - B) : B);
  assign w_q_mag = w_a_mag / w_b_mag;
  assign w_r_mag = w_a_mag % w_b_mag;
  assign w_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
  assign w_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

  // Next-state and next-register logic
  always_comb begin
    w_state_nx   = r_state;
    w_cnt_nx     = r_cnt;
    w_pend_hi_nx = r_pend_hi;
    w_pend_lo_nx = r_pend_lo;
    w_pend_wr_nx = r_pend_wr;
    w_hi_nx      = r_hi;
    w_lo_nx      = r_lo;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (mul_div_op)
            OP_MULT: begin
              {w_pend_hi_nx, w_pend_lo_nx} = w_smul;
              w_pend_wr_nx = 1'b1;
              w_cnt_nx     = CNT_W'(MULT_CYCLES);
              w_state_nx   = S_BUSY;
            end
            OP_MULTU: begin
              {w_pend_hi_nx, w_pend_lo_nx} = w_umul;
              w_pend_wr_nx = 1'b1;
              w_cnt_nx     = CNT_W'(MULT_CYCLES);
              w_state_nx   = S_BUSY;
            end
            OP_DIV, OP_DIVU: begin
              w_pend_hi_nx = w_rem;
              w_pend_lo_nx = w_quot;
              w_pend_wr_nx = (B != 32'd0);
              w_cnt_nx     = CNT_W'(DIV_CYCLES);
              w_state_nx   = S_BUSY;
            end
            OP_MTHI: w_hi_nx = A;
            OP_MTLO: w_lo_nx = A;
            default: ;
          endcase
        end
      end
      default: begin
        w_cnt_nx = r_cnt - CNT_W'(1);
        if (r_cnt <= CNT_W'(1)) begin
          w_state_nx   = S_IDLE;
          w_cnt_nx     = '0;
          w_pend_wr_nx = 1'b0;
          if (r_pend_wr) begin
            w_hi_nx = r_pend_hi;
            w_lo_nx = r_pend_lo;
          end
        end
      end
    endcase
    w_busy_nx = (w_state_nx == S_BUSY);
  end

  // State and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend_hi <= '0;
      r_pend_lo <= '0;
      r_pend_wr <= 1'b0;
      r_busy    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_state   <= w_state_nx;
      r_cnt     <= w_cnt_nx;
      r_pend_hi <= w_pend_hi_nx;
      r_pend_lo <= w_pend_lo_nx;
      r_pend_wr <= w_pend_wr_nx;
      r_busy    <= w_busy_nx;
      r_hi      <= w_hi_nx;
      r_lo      <= w_lo_nx;
    end
  end

  assign busy = r_busy;
  assign Hi   = r_hi;
  assign Lo   = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed cases then random ops against an arithmetic model.
module tb_mul_div_unit;

  localparam int unsigned MULT_N = 5;
  localparam int unsigned DIV_N  = 10;

  localparam logic [3:0] MULT  = 4'b0001;
  localparam logic [3:0] MULTU = 4'b0010;
  localparam logic [3:0] DIV   = 4'b0011;
  localparam logic [3:0] DIVU  = 4'b0100;
  localparam logic [3:0] MTHI  = 4'b0101;
  localparam logic [3:0] MFHI  = 4'b0110;
  localparam logic [3:0] MFLO  = 4'b0111;
  localparam logic [3:0] MTLO  = 4'b1000;
  localparam logic [3:0] NONE  = 4'b1111;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        flush;
  logic [3:0]  mul_div_op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] Hi, Lo;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .start(start), .flush(flush),
    .mul_div_op(mul_div_op), .A(A), .B(B),
    .busy(busy), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural effect of one accepted op: new Hi/Lo and busy latency (0 = immediate)
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] nh, output logic [31:0] nl, output int lat);
    longint          sa, sb, sp;
    longint unsigned ua, ub, up;
    int              ia, ib;
    nh = exp_hi; nl = exp_lo; lat = 0;
    case (op)
      MULT: begin
        sa = $signed(a); sb = $signed(b); sp = sa * sb;
        nh = sp[63:32]; nl = sp[31:0]; lat = MULT_N;
      end
      MULTU: begin
        ua = a; ub = b; up = ua * ub;
        nh = up[63:32]; nl = up[31:0]; lat = MULT_N;
      end
      DIV: begin
        lat = DIV_N;
        ia = a; ib = b;
        if (b == 32'd0) ;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          nl = 32'h8000_0000; nh = 32'd0;
        end else begin
          nl = ia / ib; nh = ia % ib;
        end
      end
      DIVU: begin
        lat = DIV_N;
        if (b != 32'd0) begin nl = a / b; nh = a % b; end
      end
      MTHI: nh = a;
      MTLO: nl = a;
      default: ;
    endcase
  endtask

  // Issue one op at the next edge and check busy/Hi/Lo every cycle until it completes
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, input logic inj);
    logic [31:0] nh, nl, oh, ol;
    int lat;
    oh = exp_hi; ol = exp_lo;
    if (fl) begin nh = oh; nl = ol; lat = 0; end
    else model(op, a, b, nh, nl, lat);
    start = 1'b1; flush = fl; mul_div_op = op; A = a; B = b;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; A = $urandom; B = $urandom;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      chk("busy_high", {31'd0, busy}, 32'd1);
      chk("hi_hold", Hi, oh);
      chk("lo_hold", Lo, ol);
      if (inj && i == 1) begin
        start = 1'b1; mul_div_op = MTLO; A = 32'h0000_AAAA;
        @(posedge clk); #1;
        start = 1'b0; A = $urandom; B = $urandom;
      end
    end
    @(negedge clk);
    exp_hi = nh; exp_lo = nl;
    chk("busy_low", {31'd0, busy}, 32'd0);
    chk("hi_result", Hi, exp_hi);
    chk("lo_result", Lo, exp_lo);
  endtask

  initial begin
    logic [3:0] ops [9];
    logic [3:0] op;
    logic [31:0] a, b;
    ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, NONE};

    reset = 1'b0; start = 1'b0; flush = 1'b0; mul_div_op = NONE; A = '0; B = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", Hi, 32'd0);
    chk("rst_lo", Lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Reset during an in-flight mult discards it
    start = 1'b1; mul_div_op = MULT; A = 32'd3; B = 32'd4;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    @(negedge clk); #2;
    reset = 1'b0; #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_hi", Hi, 32'd0);
    chk("arst_lo", Lo, 32'd0);
    @(negedge clk); reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("no_commit_hi", Hi, 32'd0);
    chk("no_commit_lo", Lo, 32'd0);
    chk("no_commit_busy", {31'd0, busy}, 32'd0);

    issue(MULT,  32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("mult_hi_lit", Hi, 32'hFFFF_FFFF);
    chk("mult_lo_lit", Lo, 32'hFFFF_FFFE);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    chk("multu_hi_lit", Hi, 32'h0000_0001);
    chk("multu_lo_lit", Lo, 32'hFFFF_FFFE);
    issue(DIV,   32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    chk("div_lo_lit", Lo, 32'hFFFF_FFFD);
    chk("div_hi_lit", Hi, 32'hFFFF_FFFF);
    issue(DIVU,  32'd7, 32'd2, 1'b0, 1'b0);
    chk("divu_lo_lit", Lo, 32'd3);
    chk("divu_hi_lit", Hi, 32'd1);
    issue(MTHI,  32'h11, 32'd0, 1'b0, 1'b0);
    issue(MTLO,  32'h22, 32'd0, 1'b0, 1'b0);
    issue(DIVU,  32'd5, 32'd0, 1'b0, 1'b0);
    chk("div0_hi_lit", Hi, 32'h11);
    chk("div0_lo_lit", Lo, 32'h22);
    issue(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    chk("ovf_lo_lit", Lo, 32'h8000_0000);
    chk("ovf_hi_lit", Hi, 32'd0);
    issue(MTHI,  32'hDEAD_BEEF, 32'd0, 1'b0, 1'b0);
    issue(MTLO,  32'h1234_5678, 32'd0, 1'b0, 1'b0);
    chk("mthi_lit", Hi, 32'hDEAD_BEEF);
    chk("mtlo_lit", Lo, 32'h1234_5678);
    issue(MTHI,  32'h5555_5555, 32'd0, 1'b1, 1'b0);
    issue(DIV,   32'd9, 32'd3, 1'b1, 1'b0);
    chk("flush_hi_lit", Hi, 32'hDEAD_BEEF);
    issue(MULT,  32'd6, 32'd7, 1'b0, 1'b1);
    chk("inj_lo_lit", Lo, 32'd42);
    chk("inj_hi_lit", Hi, 32'd0);

    for (int k = 0; k < 30; k++) begin
      op = ops[$urandom_range(0, 8)];
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = b & 32'h0000_000F;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      issue(op, a, b, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative-latency multiply/divide unit in the E stage of the five-stage MIPS pipeline; it is the producer of the Hi/Lo registers that the E-stage output mux reads for mfhi/mflo. It accepts mult/multu/div/divu/mthi/mtlo from the E stage, holds `busy` for a fixed latency, and then commits results to Hi/Lo. The hazard unit uses `busy` to stall D-stage mul/div and mfhi/mflo instructions.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low; clears all state
- start  input  1  E-stage instruction is a mul/div-class op; sampled on rising edge
- flush  input  1  E-stage instruction is cancelled (exception/interrupt); when high, `start` is ignored
- mul_div_op  input  4  0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 1000 mtlo, 0110 mfhi, 0111 mflo, others none
- A  input  32  forwarded rs value (MFRSE)
- B  input  32  forwarded rt value (MFRTE)
- busy  output  1  operation in flight
- Hi  output  32  architectural Hi register
- Lo  output  32  architectural Lo register

## Operation
- States: IDLE, BUSY. Internal: down-counter, pending_hi, pending_lo, pending_wr (result valid flag).
- Accept condition: state IDLE, start=1, flush=0.
- mult: pending {hi,lo} = signed 64-bit A×B. multu: unsigned 64-bit A×B. Counter loads MULT_CYCLES; go BUSY.
- div: lo = signed A/B (truncate toward zero), hi = signed A%B (sign of dividend). divu: unsigned quotient/remainder. Counter loads DIV_CYCLES; go BUSY.
- div/divu with B=0: still BUSY for DIV_CYCLES; pending_wr=0, so Hi/Lo unchanged at completion.
- Signed overflow 0x80000000 / 0xFFFFFFFF: Lo=0x80000000, Hi=0x00000000.
- mthi: Hi<=A at accepting edge; mtlo: Lo<=A at accepting edge; no BUSY, counter untouched.
- mfhi/mflo/none with start: no state change (read path is external).
- BUSY: counter decrements each edge; at the edge where counter==1, if pending_wr then Hi<=pending_hi, Lo<=pending_lo; return to IDLE.
- start while BUSY: ignored entirely, including mthi/mtlo (hazard unit guarantees absence; unit stays safe).
- flush while BUSY: no effect; an accepted op always completes.
- Operands are captured at accept; later changes to A/B have no effect.
- busy = (state==BUSY), registered.

## Timing
- Reset (async assert): state IDLE, busy=0, Hi=0, Lo=0, counter=0, pending cleared; an in-flight op is discarded. Release synchronous to clk by the system.
- Accept at edge T: busy=1 during cycles T+1..T+N (N = MULT_CYCLES or DIV_CYCLES); Hi/Lo hold new values and busy=0 from cycle T+N+1.
- Back-to-back: new start accepted at the same edge that busy falls (edge ending cycle T+N) is not allowed since state is still BUSY at that edge; earliest accept is the edge ending cycle T+N+1 (i.e., after busy observed low). Hazard unit stalls while busy=1.
- mthi/mtlo accepted at edge T: new Hi/Lo visible in cycle T+1.
- Hi/Lo never change while busy=1.

## Test plan
- Reset mid-op: mult accepted, assert reset at cycle T+2 -> busy=0, Hi=Lo=0 immediately; no later commit.
- mult A=0xFFFFFFFF B=0x00000002 -> busy 5 cycles, then Hi=0xFFFFFFFF Lo=0xFFFFFFFE; multu same operands -> Hi=0x00000001 Lo=0xFFFFFFFE.
- div A=0xFFFFFFF9 (−7) B=2 -> busy 10 cycles, Lo=0xFFFFFFFD, Hi=0xFFFFFFFF; divu A=7 B=2 -> Lo=3, Hi=1.
- Hi=0x11, Lo=0x22, divu A=5 B=0 -> busy 10 cycles, Hi/Lo stay 0x11/0x22; div 0x80000000/0xFFFFFFFF -> Lo=0x80000000 Hi=0.
- mthi A=0xDEADBEEF then mtlo A=0x12345678 on consecutive edges -> Hi/Lo update next cycle each, busy stays 0; start with flush=1 -> no change.
- During mult busy, pulse start with mtlo A=0xAAAA and change A/B -> Lo not written by mtlo, final result uses captured operands.
